// File: rtl/fab_swm_pkg.sv
// Shared types, defaults and sizing helpers for the configurable switch matrix.
// A select field equal to the input count routes constant 0.
package fab_swm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        LOADED = 2'd2
    } swm_state_t;

    localparam int N_IN_DEF     = 40;
    localparam int N_OUT_DEF    = 44;
    localparam int ZERO_SEL_DEF = N_IN_DEF;

    function automatic int sel_w(input int n_in);
        return $clog2(n_in + 1);
    endfunction

    function automatic int zero_sel(input int n_in);
        return n_in;
    endfunction

endpackage

// File: rtl/cfg_switch_matrix_if.sv
// Routed data buses plus the serial configuration handshake of the switch matrix.
interface cfg_switch_matrix_if #(
    parameter int N_IN  = 40,
    parameter int N_OUT = 44
);
    logic [N_IN-1:0]  in_bus;
    logic [N_OUT-1:0] out_bus;
    logic             cfg_start;
    logic             cfg_valid;
    logic             cfg_bit;
    logic             cfg_ready;
    logic             cfg_commit;
    logic             cfg_loaded;
    logic             cfg_done;
    logic             cfg_err;

    modport master (
        output in_bus, cfg_start, cfg_valid, cfg_bit, cfg_commit,
        input  out_bus, cfg_ready, cfg_loaded, cfg_done, cfg_err
    );

    modport slave (
        input  in_bus, cfg_start, cfg_valid, cfg_bit, cfg_commit,
        output out_bus, cfg_ready, cfg_loaded, cfg_done, cfg_err
    );
endinterface

// File: rtl/swm_cfg_loader.sv
// Serial config loader: shadow shift chain, bit counter and IDLE/SHIFT/LOADED FSM.
// Latency: one bit per accepted cycle; cfg_done/cfg_err pulse the cycle after the commit request.
// Backpressure: cfg_ready only in SHIFT; bits offered in LOADED are dropped.
module swm_cfg_loader
    import fab_swm_pkg::*;
#(
    parameter int CFG_BITS = 264
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    input  logic                cfg_bit,
    input  logic                cfg_commit,
    output logic                cfg_ready,
    output logic                cfg_loaded,
    output logic                cfg_done,
    output logic                cfg_err,
    output logic                commit_fire,
    output logic [CFG_BITS-1:0] shadow
);
    localparam int CNT_W = $clog2(CFG_BITS + 1);

    swm_state_t       state, state_nxt;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             commit_bad;

    always_ff @(posedge CLK) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // cfg_start wins over everything, including a commit in the same cycle.
    always_comb begin
        state_nxt   = state;
        cfg_ready   = (state == SHIFT);
        cfg_loaded  = (state == LOADED);
        accept      = 1'b0;
        commit_fire = 1'b0;
        commit_bad  = 1'b0;
        if (cfg_start) begin
            state_nxt = SHIFT;
        end else begin
            case (state)
                IDLE: commit_bad = cfg_commit;
                SHIFT: begin
                    accept     = cfg_valid;
                    commit_bad = cfg_commit;
                    if (cfg_valid && count == CNT_W'(CFG_BITS - 1)) state_nxt = LOADED;
                end
                LOADED: begin
                    if (cfg_commit) begin
                        commit_fire = 1'b1;
                        state_nxt   = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            count    <= '0;
            shadow   <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_done <= commit_fire;
            cfg_err  <= commit_bad;
            if (cfg_start) begin
                count  <= '0;
                shadow <= '0;
            end else if (accept) begin
                shadow <= {shadow[CFG_BITS-2:0], cfg_bit};
                count  <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cfg_switch_matrix.sv
// Runtime-configurable N_IN -> N_OUT switch matrix; each output picks one input or constant 0.
// Latency: 0 cycles in_bus->out_bus, or 1 cycle when CFG_SWM_OUT_REG_EN is defined.
// Backpressure: none on the data path; config loads through the cfg_ready handshake and commits atomically.
module cfg_switch_matrix
    import fab_swm_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int N_OUT = N_OUT_DEF
) (
    input  logic          CLK,
    input  logic          reset,
    cfg_switch_matrix_if.slave sw
);
    localparam int SEL_W    = sel_w(N_IN);
    localparam int CFG_BITS = N_OUT * SEL_W;
    localparam int ZERO_SEL = zero_sel(N_IN);
    localparam int PAD_W    = 1 << SEL_W;

    logic [CFG_BITS-1:0] shadow;
    logic [CFG_BITS-1:0] active;
    logic                commit_fire;
    logic [PAD_W-1:0]    in_pad;
    logic [N_OUT-1:0]    routed;

    swm_cfg_loader #(.CFG_BITS(CFG_BITS)) u_loader (
        .CLK         (CLK),
        .reset       (reset),
        .cfg_start   (sw.cfg_start),
        .cfg_valid   (sw.cfg_valid),
        .cfg_bit     (sw.cfg_bit),
        .cfg_commit  (sw.cfg_commit),
        .cfg_ready   (sw.cfg_ready),
        .cfg_loaded  (sw.cfg_loaded),
        .cfg_done    (sw.cfg_done),
        .cfg_err     (sw.cfg_err),
        .commit_fire (commit_fire),
        .shadow      (shadow)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int j = 0; j < N_OUT; j++) active[j*SEL_W +: SEL_W] <= SEL_W'(ZERO_SEL);
        end else if (commit_fire) begin
            active <= shadow;
        end
    end

    // Zero-padding the inputs to the full select range makes every select >= N_IN read 0.
    always_comb begin
        in_pad         = '0;
        in_pad[N_IN-1:0] = sw.in_bus;
        routed         = '0;
        for (int j = 0; j < N_OUT; j++) routed[j] = in_pad[active[j*SEL_W +: SEL_W]];
    end

`ifdef CFG_SWM_OUT_REG_EN
    logic [N_OUT-1:0] out_q;

    always_ff @(posedge CLK) begin
        if (reset) out_q <= '0;
        else       out_q <= routed;
    end

    assign sw.out_bus = out_q;
`else
    assign sw.out_bus = routed;
`endif

endmodule
